// File: rtl/map_pkg.sv
`default_nettype none
// ============================================================================
// map_pkg
//   Shared sprite codes, request opcodes and writer state encoding.
//   Rev 1.0 - initial release
// ============================================================================
package map_pkg;

  localparam logic [2:0] SPR_BLACK     = 3'b000;
  localparam logic [2:0] SPR_BIG_ORB   = 3'b001;
  localparam logic [2:0] SPR_SMALL_ORB = 3'b010;
  localparam logic [2:0] SPR_BLUE      = 3'b011;
  localparam logic [2:0] SPR_GREY      = 3'b100;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_EAT   = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CHECK = 3'd2,
    S_WRITE = 3'd3,
    S_FILL  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/map_tile_writer_if.sv
`default_nettype none
// ============================================================================
// map_tile_writer_if
//   Request channel, map RAM port and status signals of the tile writer.
//   Rev 1.0 - initial release
// ============================================================================
interface map_tile_writer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [4:0]  req_x;
  logic [4:0]  req_y;
  logic [2:0]  req_type;
  logic [4:0]  mem_x;
  logic [4:0]  mem_y;
  logic [2:0]  mem_rd_type;
  logic        mem_we;
  logic [2:0]  mem_wr_type;
  logic        eaten;
  logic        eaten_big;
  logic [15:0] score;
  logic        busy;
  logic        err;

  modport slave (
    input  req_valid, req_op, req_x, req_y, req_type, mem_rd_type,
    output req_ready, mem_x, mem_y, mem_we, mem_wr_type,
           eaten, eaten_big, score, busy, err
  );

  modport master (
    output req_valid, req_op, req_x, req_y, req_type, mem_rd_type,
    input  req_ready, mem_x, mem_y, mem_we, mem_wr_type,
           eaten, eaten_big, score, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/map_raster_counter.sv
`default_nettype none
// ============================================================================
// map_raster_counter
//   Raster-order tile counter, x fastest, both axes wrapping at MAX.
//   Rev 1.0 - initial release
// ============================================================================
module map_raster_counter #(
  parameter int MAX = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [4:0] x_o,
  output logic [4:0] y_o,
  output logic       last_o
);
  localparam logic [4:0] MAX_C = 5'(MAX);

  logic [4:0] x_q;
  logic [4:0] y_q;

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      x_q <= 5'd0;
      y_q <= 5'd0;
    end else if (en_i) begin
      if (x_q == MAX_C) begin
        x_q <= 5'd0;
        y_q <= (y_q == MAX_C) ? 5'd0 : y_q + 5'd1;
      end else begin
        x_q <= x_q + 5'd1;
      end
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == MAX_C) && (y_q == MAX_C);
endmodule
`default_nettype wire

// File: rtl/map_tile_writer.sv
`default_nettype none
// ============================================================================
// map_tile_writer
//   Map RAM tile writer: single writes, orb eating with scoring, full fill.
//   Optional feature macro: SCORE_COUNTER_EN (builds the saturating score).
//   Rev 1.0 - initial release
// ============================================================================
module map_tile_writer
  import map_pkg::*;
#(
  parameter int MAP_MAX   = 20,
  parameter int SMALL_PTS = 10,
  parameter int BIG_PTS   = 50
) (
  input  logic               clk,
  input  logic               reset,
  map_tile_writer_if.slave   tw
);
  localparam logic [4:0] MAX_C = 5'(MAP_MAX);

  state_e     state_q, state_d;
  logic [1:0] op_q;
  logic [4:0] x_q, y_q;
  logic [2:0] type_q;
  logic [2:0] tile_q;
  logic       err_q, err_d;

  logic       ready, accept, bad_req;
  logic       we, eat_pulse, eat_big, ras_en, ras_last;
  logic [2:0] wr_type;
  logic [4:0] ras_x, ras_y;

  assign accept  = tw.req_valid && (state_q == S_IDLE);
  // FILL ignores coordinates, so only WRITE/EAT are range-checked
  assign bad_req = (tw.req_op == OP_RSVD) ||
                   ((tw.req_op != OP_FILL) && ((tw.req_x > MAX_C) || (tw.req_y > MAX_C)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_WRITE;
      x_q     <= 5'd0;
      y_q     <= 5'd0;
      type_q  <= SPR_BLACK;
      tile_q  <= SPR_BLACK;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (accept) begin
        op_q   <= tw.req_op;
        x_q    <= tw.req_x;
        y_q    <= tw.req_y;
        type_q <= tw.req_type;
      end
      if (state_q == S_CHECK) tile_q <= tw.mem_rd_type;
    end
  end

  always_comb begin
    state_d   = state_q;
    err_d     = 1'b0;
    ready     = 1'b0;
    we        = 1'b0;
    wr_type   = SPR_BLACK;
    eat_pulse = 1'b0;
    eat_big   = 1'b0;
    ras_en    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (tw.req_valid) begin
          if (bad_req) begin
            err_d = 1'b1;
          end else begin
            unique case (tw.req_op)
              OP_EAT:  state_d = S_READ;
              OP_FILL: state_d = S_FILL;
              default: state_d = S_WRITE;
            endcase
          end
        end
      end
      S_READ:  state_d = S_CHECK;
      S_CHECK: begin
        if ((tw.mem_rd_type == SPR_BIG_ORB) || (tw.mem_rd_type == SPR_SMALL_ORB))
          state_d = S_WRITE;
        else
          state_d = S_IDLE;
      end
      S_WRITE: begin
        we      = 1'b1;
        state_d = S_IDLE;
        if (op_q == OP_EAT) begin
          wr_type   = SPR_BLACK;
          eat_pulse = 1'b1;
          eat_big   = (tile_q == SPR_BIG_ORB);
        end else begin
          wr_type = type_q;
        end
      end
      S_FILL: begin
        we      = 1'b1;
        wr_type = type_q;
        ras_en  = 1'b1;
        if (ras_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  map_raster_counter #(
    .MAX (MAP_MAX)
  ) u_raster (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (state_q != S_FILL),
    .en_i   (ras_en),
    .x_o    (ras_x),
    .y_o    (ras_y),
    .last_o (ras_last)
  );

`ifdef SCORE_COUNTER_EN
  logic [15:0] score_q, score_d;
  logic [16:0] score_sum;

  always_comb begin
    score_sum = {1'b0, score_q} +
                ((tile_q == SPR_BIG_ORB) ? 17'(BIG_PTS) : 17'(SMALL_PTS));
    score_d   = score_q;
    if (eat_pulse) score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) score_q <= 16'd0;
    else       score_q <= score_d;
  end

  assign tw.score = score_q;
`else
  assign tw.score = 16'd0;
`endif

  assign tw.req_ready   = ready;
  assign tw.mem_x       = (state_q == S_FILL) ? ras_x : x_q;
  assign tw.mem_y       = (state_q == S_FILL) ? ras_y : y_q;
  assign tw.mem_we      = we;
  assign tw.mem_wr_type = wr_type;
  assign tw.eaten       = eat_pulse;
  assign tw.eaten_big   = eat_big;
  assign tw.busy        = (state_q != S_IDLE);
  assign tw.err         = err_q;
endmodule
`default_nettype wire

// File: tb/tb_map_tile_writer.sv
`default_nettype none
// ============================================================================
// tb_map_tile_writer
//   Directed, table-driven bench for map_tile_writer with a map RAM model.
//   Rev 1.0 - initial release
// ============================================================================
module tb_map_tile_writer;
  import map_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  map_tile_writer_if bus ();

  map_tile_writer dut (
    .clk   (clk),
    .reset (reset),
    .tw    (bus)
  );

  // map RAM with one-cycle read latency, stored [y][x]
  logic [2:0] ram [0:20][0:20];
  always @(posedge clk) begin
    if (bus.mem_we && bus.mem_x <= 5'd20 && bus.mem_y <= 5'd20)
      ram[bus.mem_y][bus.mem_x] <= bus.mem_wr_type;
    if (bus.mem_x <= 5'd20 && bus.mem_y <= 5'd20)
      bus.mem_rd_type <= ram[bus.mem_y][bus.mem_x];
    else
      bus.mem_rd_type <= 3'b000;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_score(input int v);
`ifdef SCORE_COUNTER_EN
    return v;
`else
    return 0;
`endif
  endfunction

  typedef struct {
    int we_cnt, busy_cnt, eaten_cnt, big_cnt, err_cnt;
    int first_x, first_y, last_x, last_y, last_d;
    int rdy_bad, order_bad, timeout;
  } obs_t;

  typedef struct {
    logic [1:0] op;
    logic [4:0] x, y;
    logic [2:0] t;
    int we, busy, eaten, big, err;
    int lx, ly, ld;
    int score;
  } vec_t;

  task automatic do_req(input logic [1:0] op, input logic [4:0] x, input logic [4:0] y,
                        input logic [2:0] t, output obs_t o);
    int ex, ey;
    bit done;
    o = '{default: 0};
    ex = 0; ey = 0; done = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_x     = x;
    bus.req_y     = y;
    bus.req_type  = t;
    if (!bus.req_ready) o.rdy_bad++;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.busy && bus.req_ready) o.rdy_bad++;
      if (bus.err) o.err_cnt++;
      if (bus.mem_we) begin
        if (o.we_cnt == 0) begin
          o.first_x = int'(bus.mem_x);
          o.first_y = int'(bus.mem_y);
        end
        o.last_x = int'(bus.mem_x);
        o.last_y = int'(bus.mem_y);
        o.last_d = int'(bus.mem_wr_type);
        if (int'(bus.mem_x) != ex || int'(bus.mem_y) != ey) o.order_bad++;
        if (ex == 20) begin ex = 0; ey++; end else ex++;
        o.we_cnt++;
      end
      if (bus.eaten) begin
        o.eaten_cnt++;
        if (bus.eaten_big) o.big_cnt++;
      end
      if (bus.busy) o.busy_cnt++;
      else begin done = 1'b1; break; end
    end
    if (!done) o.timeout = 1;
  endtask

  vec_t vecs [13];
  obs_t o;
  bit   found;

  initial begin
    for (int yy = 0; yy <= 20; yy++)
      for (int xx = 0; xx <= 20; xx++)
        ram[yy][xx] = 3'b000;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_x     = 5'd0;
    bus.req_y     = 5'd0;
    bus.req_type  = 3'b000;

    //            op     x      y      t     we   busy ea big err lx  ly  ld  score
    vecs[0]  = '{2'd0, 5'd3,  5'd4,  3'd3, 1,   1,   0, 0, 0,  3,  4,  3,  0};
    vecs[1]  = '{2'd0, 5'd5,  5'd5,  3'd1, 1,   1,   0, 0, 0,  5,  5,  1,  0};
    vecs[2]  = '{2'd0, 5'd6,  5'd6,  3'd2, 1,   1,   0, 0, 0,  6,  6,  2,  0};
    vecs[3]  = '{2'd1, 5'd5,  5'd5,  3'd0, 1,   3,   1, 1, 0,  5,  5,  0,  50};
    vecs[4]  = '{2'd1, 5'd5,  5'd5,  3'd0, 0,   2,   0, 0, 0,  0,  0,  0,  50};
    vecs[5]  = '{2'd1, 5'd6,  5'd6,  3'd0, 1,   3,   1, 0, 0,  6,  6,  0,  60};
    vecs[6]  = '{2'd1, 5'd3,  5'd4,  3'd0, 0,   2,   0, 0, 0,  0,  0,  0,  60};
    vecs[7]  = '{2'd0, 5'd21, 5'd0,  3'd3, 0,   0,   0, 0, 1,  0,  0,  0,  60};
    vecs[8]  = '{2'd1, 5'd0,  5'd21, 3'd0, 0,   0,   0, 0, 1,  0,  0,  0,  60};
    vecs[9]  = '{2'd3, 5'd2,  5'd2,  3'd1, 0,   0,   0, 0, 1,  0,  0,  0,  60};
    vecs[10] = '{2'd0, 5'd20, 5'd20, 3'd4, 1,   1,   0, 0, 0,  20, 20, 4,  60};
    vecs[11] = '{2'd2, 5'd0,  5'd0,  3'd2, 441, 441, 0, 0, 0,  20, 20, 2,  60};
    vecs[12] = '{2'd1, 5'd20, 5'd20, 3'd0, 1,   3,   1, 0, 0,  20, 20, 0,  70};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_we",   int'(bus.mem_we), 0);
    check("rst_wr_type",  int'(bus.mem_wr_type), 0);
    check("rst_eaten",    int'(bus.eaten), 0);
    check("rst_eaten_big",int'(bus.eaten_big), 0);
    check("rst_err",      int'(bus.err), 0);
    check("rst_score",    int'(bus.score), 0);
    check("rst_busy",     int'(bus.busy), 0);
    check("rst_mem_x",    int'(bus.mem_x), 0);
    check("rst_mem_y",    int'(bus.mem_y), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", int'(bus.req_ready), 1);

    for (int i = 0; i < 13; i++) begin
      do_req(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].t, o);
      check($sformatf("v%0d_timeout", i), o.timeout, 0);
      check($sformatf("v%0d_we_cycles", i), o.we_cnt, vecs[i].we);
      check($sformatf("v%0d_busy_cycles", i), o.busy_cnt, vecs[i].busy);
      check($sformatf("v%0d_eaten", i), o.eaten_cnt, vecs[i].eaten);
      check($sformatf("v%0d_eaten_big", i), o.big_cnt, vecs[i].big);
      check($sformatf("v%0d_err", i), o.err_cnt, vecs[i].err);
      check($sformatf("v%0d_ready", i), o.rdy_bad, 0);
      check($sformatf("v%0d_score", i), int'(bus.score), exp_score(vecs[i].score));
      if (vecs[i].we > 0) begin
        check($sformatf("v%0d_last_x", i), o.last_x, vecs[i].lx);
        check($sformatf("v%0d_last_y", i), o.last_y, vecs[i].ly);
        check($sformatf("v%0d_wr_data", i), o.last_d, vecs[i].ld);
      end
      if (vecs[i].op == OP_FILL) begin
        check("fill_first_x", o.first_x, 0);
        check("fill_first_y", o.first_y, 0);
        check("fill_raster_order", o.order_bad, 0);
      end
    end

    // reset while filling, at tile index 100 = (16,4)
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_FILL;
    bus.req_type  = SPR_BLUE;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.mem_we && bus.mem_x == 5'd16 && bus.mem_y == 5'd4) begin
        found = 1'b1;
        reset = 1'b1;
        break;
      end
    end
    check("fill_reach_tile100", int'(found), 1);
    @(negedge clk);
    check("abort_mem_we", int'(bus.mem_we), 0);
    check("abort_busy",   int'(bus.busy), 0);
    check("abort_score",  int'(bus.score), 0);
    check("abort_mem_x",  int'(bus.mem_x), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_ready",     int'(bus.req_ready), 1);
    check("abort_mem_we2",   int'(bus.mem_we), 0);
    check("abort_tile100",   int'(ram[4][16]), 3);
    check("abort_tile101",   int'(ram[4][17]), 2);
    check("abort_tile_last", int'(ram[20][20]), 0);

    // saturation: 1310 big orbs reach 65500, the next must clamp
    for (int i = 0; i < 1310; i++) begin
      do_req(OP_WRITE, 5'd1, 5'd1, SPR_BIG_ORB, o);
      do_req(OP_EAT,   5'd1, 5'd1, SPR_BLACK,   o);
    end
    check("score_65500", int'(bus.score), exp_score(65500));
    do_req(OP_WRITE, 5'd1, 5'd1, SPR_BIG_ORB, o);
    do_req(OP_EAT,   5'd1, 5'd1, SPR_BLACK,   o);
    check("sat_eaten_big", o.big_cnt, 1);
    check("score_sat", int'(bus.score), exp_score(65535));
    do_req(OP_WRITE, 5'd1, 5'd1, SPR_SMALL_ORB, o);
    do_req(OP_EAT,   5'd1, 5'd1, SPR_BLACK,     o);
    check("score_sat_hold", int'(bus.score), exp_score(65535));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
